// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: state encoding and the
// prescaler width helper.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Prescaler counter width; a single bit is kept as a floor so a
  // degenerate PRESCALE still elaborates.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the last count
// as a time-unit tick.
module tick_gen
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = presc_width(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign tick = en && (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: one-shot or periodic, with pause, abort and
// restart, producing a registered single-cycle done strobe.
module interval_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               periodic,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] elapsed
);

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] term_reg, term_next;
  logic               mode_reg, mode_next;
  logic [COUNT_W-1:0] elapsed_reg, elapsed_next;
  logic               done_reg, done_next;
  logic               tick;
  logic               presc_en;
  logic               presc_clr;

  // The prescaler restarts from zero on any start/abort and stays cleared in IDLE.
  assign presc_en  = (state_reg == RUN) && active;
  assign presc_clr = abort || start || (state_reg == IDLE);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (presc_en),
    .clr (presc_clr),
    .tick(tick)
  );

  always_comb begin
    state_next   = state_reg;
    term_next    = term_reg;
    mode_next    = mode_reg;
    elapsed_next = elapsed_reg;
    done_next    = 1'b0;
    if (abort) begin
      state_next   = IDLE;
      elapsed_next = '0;
    end else if (start) begin
      elapsed_next = '0;
      if (load_value != '0) begin
        term_next  = load_value;
        mode_next  = periodic;
        state_next = RUN;
      end else begin
        // A zero load is ignored in IDLE and acts as an abort in RUN.
        state_next = IDLE;
      end
    end else if ((state_reg == RUN) && tick) begin
      if (elapsed_reg == term_reg - COUNT_W'(1)) begin
        done_next    = 1'b1;
        elapsed_next = '0;
        if (!mode_reg) begin
          state_next = IDLE;
        end
      end else begin
        elapsed_next = elapsed_reg + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      term_reg    <= '0;
      mode_reg    <= 1'b0;
      elapsed_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      term_reg    <= term_next;
      mode_reg    <= mode_next;
      elapsed_reg <= elapsed_next;
      done_reg    <= done_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = done_reg;
  assign elapsed = elapsed_reg;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: a table of interval runs plus
// hand-written sequences for pause, abort, restart, zero load and reset.
module tb_interval_timer;

  localparam int P = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          active = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] load_value = '0;
  logic          periodic = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] elapsed;

  int errors = 0;
  int checks = 0;

  interval_timer #(
    .PRESCALE(P),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .active    (active),
    .start     (start),
    .abort     (abort),
    .load_value(load_value),
    .periodic  (periodic),
    .busy      (busy),
    .done      (done),
    .elapsed   (elapsed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] load;
    logic          per;
    int            exp_done;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n, input logic per);
    start = 1'b1;
    load_value = n;
    periodic = per;
    step();
    start = 1'b0;
    load_value = '0;
    periodic = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    int first;
    int bad_el;
    int peak;
    int busy_at;
    int cnt;
    int pos;
    int bad;
    int q[$];

    vecs[0] = '{load: 8'd3,   per: 1'b0, exp_done: 12,   exp_busy: 1'b0};
    vecs[1] = '{load: 8'd1,   per: 1'b0, exp_done: 4,    exp_busy: 1'b0};
    vecs[2] = '{load: 8'd2,   per: 1'b1, exp_done: 8,    exp_busy: 1'b1};
    vecs[3] = '{load: 8'd255, per: 1'b0, exp_done: 1020, exp_busy: 1'b0};

    // Reset state
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_elapsed", int'(elapsed), 0);
    rst = 1'b0;
    step();

    // Table-driven interval runs
    for (int v = 0; v < 4; v++) begin
      do_start(vecs[v].load, vecs[v].per);
      chk("start_busy", int'(busy), 1);
      chk("start_elapsed", int'(elapsed), 0);
      first = -1;
      bad_el = 0;
      peak = 0;
      busy_at = -1;
      for (int k = 1; k <= 1100; k++) begin
        step();
        if (done === 1'b1) begin
          first = k;
          busy_at = int'(busy);
          break;
        end
        if (int'(elapsed) != k / P) bad_el++;
        if (int'(elapsed) > peak) peak = int'(elapsed);
      end
      chk("done_edge", first, vecs[v].exp_done);
      chk("busy_at_done", busy_at, int'(vecs[v].exp_busy));
      chk("elapsed_profile_errors", bad_el, 0);
      chk("elapsed_peak", peak, int'(vecs[v].load) - 1);
      step();
      chk("done_one_cycle", int'(done), 0);
      $display("vec %0d: N=%0d periodic=%0d done_at=%0d busy_at_done=%0d peak=%0d",
               v, vecs[v].load, vecs[v].per, first, busy_at, peak);
      do_abort();
      chk("cleanup_idle", int'(busy), 0);
    end

    // Periodic N=2: done at E0+8, +16, +24 with busy held
    do_start(8'd2, 1'b1);
    bad = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (done === 1'b1) q.push_back(k);
      if (busy !== 1'b1) bad++;
    end
    chk("periodic_done_count", q.size(), 3);
    chk("periodic_done0", (q.size() > 0) ? q[0] : -1, 8);
    chk("periodic_done1", (q.size() > 1) ? q[1] : -1, 16);
    chk("periodic_done2", (q.size() > 2) ? q[2] : -1, 24);
    chk("periodic_busy_drops", bad, 0);
    $display("periodic N=2: done count=%0d", q.size());
    do_abort();

    // Pause: active low for 5 cycles from E0+6 moves done to E0+17
    do_start(8'd3, 1'b0);
    for (int k = 1; k <= 6; k++) step();
    chk("pause_elapsed_before", int'(elapsed), 1);
    active = 1'b0;
    bad = 0;
    for (int k = 7; k <= 11; k++) begin
      step();
      if (elapsed !== 8'd1) bad++;
      if (done !== 1'b0) bad++;
    end
    chk("pause_hold_errors", bad, 0);
    active = 1'b1;
    first = -1;
    for (int k = 12; k <= 40; k++) begin
      step();
      if (done === 1'b1) begin
        first = k;
        break;
      end
    end
    chk("pause_done_edge", first, 17);
    $display("pause N=3: done_at=%0d", first);
    step();

    // Abort at E0+10: IDLE at E0+11, no done afterwards
    do_start(8'd3, 1'b0);
    for (int k = 1; k <= 10; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_elapsed", int'(elapsed), 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) cnt++;
      step();
    end
    chk("abort_no_done", cnt, 0);
    $display("abort at E0+10: busy=%0d done_seen=%0d", busy, cnt);

    // Abort and start together from IDLE
    abort = 1'b1;
    start = 1'b1;
    load_value = 8'd3;
    step();
    abort = 1'b0;
    start = 1'b0;
    load_value = '0;
    chk("abort_start_idle", int'(busy), 0);

    // Restart at E0+6 with N=1: done only at E0+10
    do_start(8'd3, 1'b0);
    for (int k = 1; k <= 5; k++) step();
    start = 1'b1;
    load_value = 8'd1;
    step();
    start = 1'b0;
    load_value = '0;
    chk("restart_elapsed", int'(elapsed), 0);
    cnt = 0;
    pos = -1;
    for (int k = 7; k <= 30; k++) begin
      step();
      if (done === 1'b1) begin
        cnt++;
        pos = k;
      end
    end
    chk("restart_done_count", cnt, 1);
    chk("restart_done_edge", pos, 10);
    $display("restart N=1: done count=%0d at=%0d", cnt, pos);

    // Zero load in IDLE is ignored
    do_start(8'd0, 1'b0);
    chk("zero_load_idle", int'(busy), 0);
    step();
    chk("zero_load_idle_later", int'(busy), 0);

    // Zero load in RUN acts as abort
    do_start(8'd5, 1'b0);
    for (int k = 0; k < 6; k++) step();
    do_start(8'd0, 1'b0);
    chk("zero_load_run_busy", int'(busy), 0);
    chk("zero_load_run_elapsed", int'(elapsed), 0);

    // Asynchronous reset mid-run
    do_start(8'd3, 1'b0);
    for (int k = 0; k < 8; k++) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_elapsed", int'(elapsed), 0);
    chk("async_rst_done", int'(done), 0);
    #2;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("post_reset_quiet", cnt, 0);
    $display("reset mid-run: busy=%0d elapsed=%0d", busy, elapsed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
